// File: rtl/restador_serie9b_pkg.sv
// restador_serie9b_pkg: shared constants and state encoding for the bit-serial subtractor
package restador_serie9b_pkg;

    localparam int W_DEF = 9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/restador_serie9b_fs_exacto.sv
// fs_exacto: exact one-bit full subtractor, mirror of the adder's full-adder cell
module fs_exacto (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // difference and borrow-out of a - b - bin
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/restador_serie9b.sv
// restador_serie9b: bit-serial exact subtractor, one bit per clock, LSB first
module restador_serie9b
    import restador_serie9b_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         valid,
    output logic [W:0]   D
);

    localparam int CW = cnt_w(W);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    d_q, d_d;
    logic          bor_q, bor_d, valid_q, valid_d;
    logic          dif, bout;

    fs_exacto u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bor_q),
        .d    (dif),
        .bout (bout)
    );

    // next-state: capture operands in IDLE, shift one bit per edge in RUN
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        bor_d   = bor_q;
        d_d     = d_q;
        valid_d = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                a_d     = A;
                b_d     = B;
                bor_d   = 1'b0;
                cnt_d   = '0;
                state_d = RUN;
            end
        end else begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = {dif, res_q[W-1:1]};
            bor_d = bout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                d_d     = {bout, dif, res_q[W-1:1]};
                valid_d = 1'b1;
                state_d = IDLE;
            end
        end
    end

    // state and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            bor_q   <= 1'b0;
            d_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            bor_q   <= bor_d;
            d_q     <= d_d;
            valid_q <= valid_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign valid = valid_q;
    assign D     = d_q;

endmodule

// File: tb/tb_restador_serie9b.sv
// tb_restador_serie9b: scoreboard bench for the bit-serial subtractor
module tb_restador_serie9b;

    typedef struct {
        logic [9:0] d;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] A = '0;
    logic [8:0] B = '0;
    logic       busy, valid;
    logic [9:0] D;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic vprev = 1'b0;
    exp_t sb[$];

    restador_serie9b dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .valid (valid),
        .D     (D)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard: every valid must match the oldest pending operation, 9 edges after acceptance
    always @(negedge clk) begin
        if (rst) begin
            vprev <= 1'b0;
        end else begin
            if (valid) begin
                check("valid_one_cycle", {31'b0, vprev}, 32'd0);
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("D", {22'b0, D}, {22'b0, e.d});
                    check("latency", cyc - e.acc, 32'd9);
                end
            end
            vprev <= valid;
        end
    end

    // called at a negedge while idle; returns at the negedge after the accepting edge
    task automatic go(input logic [8:0] a, input logic [8:0] b);
        exp_t e;
        start = 1'b1;
        A = a;
        B = b;
        e.d = 10'(int'(a) - int'(b));
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A = 9'($urandom);
        B = 9'($urandom);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", {31'b0, valid}, 32'd1);
    endtask

    initial begin
        int n;
        exp_t e;
        #2;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_D", {22'b0, D}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        go(9'd200, 9'd45);
        n = 0;
        while (!valid && n < 30) begin
            n += int'(busy);
            @(negedge clk);
        end
        check("busy_cycles", n, 32'd9);
        check("busy_low_at_valid", {31'b0, busy}, 32'd0);
        check("D_155", {22'b0, D}, 32'h09B);
        @(negedge clk);
        check("valid_drops", {31'b0, valid}, 32'd0);
        check("D_holds", {22'b0, D}, 32'h09B);

        go(9'd45, 9'd200);
        wait_valid();
        check("borrow_set", {31'b0, D[9]}, 32'd1);
        go(9'd511, 9'd0);
        wait_valid();
        check("max_pos", {22'b0, D}, 32'h1FF);
        go(9'd0, 9'd511);
        wait_valid();
        check("max_neg", {22'b0, D}, 32'h201);
        go(9'd300, 9'd300);
        wait_valid();
        check("zero", {22'b0, D}, 32'h000);
        @(negedge clk);

        go(9'd10, 9'd3);
        repeat (2) @(negedge clk);
        start = 1'b1;
        A = 9'd1;
        B = 9'd1;
        @(negedge clk);
        start = 1'b0;
        check("busy_mid", {31'b0, busy}, 32'd1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("hs_valid", {31'b0, valid}, 32'd1);
        check("hs_D", {22'b0, D}, 32'h007);
        e.d = 10'd0;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("hs_accept_busy", {31'b0, busy}, 32'd1);
        wait_valid();
        @(negedge clk);

        go(9'd100, 9'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_valid", {31'b0, valid}, 32'd0);
        check("arst_D", {22'b0, D}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("no_valid_after_rst", {31'b0, valid}, 32'd0);
        go(9'd8, 9'd9);
        wait_valid();
        check("neg_one", {22'b0, D}, 32'h3FF);

        for (int i = 0; i < 1000; i++) begin
            go(9'($urandom), 9'($urandom));
            wait_valid();
        end
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
